// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Each grant becomes one memory access cycle followed by a one-cycle response.
module data_mem_arbiter #(
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned DEPTH    = 101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [3:0]  p0_mask,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [3:0]  p1_mask,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_cs_n,
    output logic        mem_rd,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          rr_ptr;
    logic [CW-1:0] wait_cnt;
    logic          sel_q;
    logic          we_q;
    logic          err_q;

    logic          arb;
    logic          pick1;
    logic          nx_we;
    logic          nx_err;
    logic [3:0]    nx_mask;
    logic [31:0]   nx_addr;
    logic [31:0]   nx_wdata;
    logic [31:0]   rd_word;

    // Arbitration is decided in the IDLE/RESP cycle so the grant and the payload capture share an edge.
    always_comb begin
        arb   = (state == IDLE) || (state == RESP);
        pick1 = p1_req;
        if (p0_req && p1_req) begin
            if (ARB_MODE == 0) begin
                pick1 = rr_ptr;
            end else begin
                pick1 = (wait_cnt == CW'(MAX_WAIT));
            end
        end
        p0_gnt   = arb && p0_req && !pick1;
        p1_gnt   = arb && p1_req && pick1;
        nx_we    = pick1 ? p1_we    : p0_we;
        nx_mask  = pick1 ? p1_mask  : p0_mask;
        nx_addr  = pick1 ? p1_addr  : p0_addr;
        nx_wdata = pick1 ? p1_wdata : p0_wdata;
        nx_err   = (nx_addr >= 32'(DEPTH)) || (!nx_we && (nx_mask > 4'd4));
        rd_word  = (we_q || err_q) ? 32'h0 : mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            wait_cnt  <= '0;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_cs_n  <= 1'b1;
            mem_rd    <= 1'b1;
            mem_mask  <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= 32'h0;
            p1_rdata  <= 32'h0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
        end else begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= 32'h0;
            p1_rdata  <= 32'h0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;

            // Starvation guard: counts cycles port 1 waits, saturating at MAX_WAIT.
            if ((ARB_MODE != 0) && p1_req && !p1_gnt) begin
                if (wait_cnt != CW'(MAX_WAIT)) begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                ACCESS: begin
                    mem_cs_n  <= 1'b1;
                    mem_rd    <= 1'b1;
                    p0_rvalid <= !sel_q;
                    p1_rvalid <= sel_q;
                    p0_rdata  <= sel_q ? 32'h0 : rd_word;
                    p1_rdata  <= sel_q ? rd_word : 32'h0;
                    p0_err    <= !sel_q && err_q;
                    p1_err    <= sel_q && err_q;
                    state     <= RESP;
                end
                default: begin
                    if (p0_gnt || p1_gnt) begin
                        sel_q     <= p1_gnt;
                        we_q      <= nx_we;
                        err_q     <= nx_err;
                        mem_cs_n  <= nx_err;
                        mem_rd    <= nx_err || !nx_we;
                        mem_mask  <= nx_mask;
                        mem_addr  <= nx_addr;
                        mem_wdata <= nx_wdata;
                        rr_ptr    <= !p1_gnt;
                        state     <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural memory, per-port response scoreboard,
// round-robin instance plus a fixed-priority instance for the starvation guard.
module tb_data_mem_arbiter;

    localparam int unsigned DEPTH = 101;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [3:0]  p0_mask, p1_mask;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_cs_n, mem_rd;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_p0_req, b_p1_req;
    logic        b_p0_gnt, b_p0_rvalid, b_p0_err, b_p1_gnt, b_p1_rvalid, b_p1_err;
    logic [31:0] b_p0_rdata, b_p1_rdata;
    logic        b_mem_cs_n, b_mem_rd;
    logic [3:0]  b_mem_mask;
    logic [31:0] b_mem_addr, b_mem_wdata;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    exp_t        q0[$];
    exp_t        q1[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cs_low_cnt = 0;
    int          last_cs_cyc = -1;
    int          rv0_cyc = -1;
    logic [31:0] last_rdata0 = '0;
    logic        last_err0 = 1'b0;
    logic        last_err1 = 1'b0;
    bit          last_port = 1'b0;

    data_mem_arbiter #(.ARB_MODE(0), .MAX_WAIT(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_mask(p0_mask), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_mask(p1_mask), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_cs_n(mem_cs_n), .mem_rd(mem_rd), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    data_mem_arbiter #(.ARB_MODE(1), .MAX_WAIT(8), .DEPTH(DEPTH)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req(b_p0_req), .p0_we(1'b0), .p0_mask(4'd2), .p0_addr(32'd20), .p0_wdata(32'h0),
        .p0_gnt(b_p0_gnt), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata), .p0_err(b_p0_err),
        .p1_req(b_p1_req), .p1_we(1'b0), .p1_mask(4'd2), .p1_addr(32'd21), .p1_wdata(32'h0),
        .p1_gnt(b_p1_gnt), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata), .p1_err(b_p1_err),
        .mem_cs_n(b_mem_cs_n), .mem_rd(b_mem_rd), .mem_mask(b_mem_mask), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ld(input logic [31:0] w, input logic [3:0] c);
        case (c)
            4'd0:    return {{24{w[7]}}, w[7:0]};
            4'd1:    return {{16{w[15]}}, w[15:0]};
            4'd2:    return w;
            4'd3:    return {24'h0, w[7:0]};
            4'd4:    return {16'h0, w[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Memory: combinational read with load-code extraction, byte-enabled write on the clock.
    always_comb begin
        mem_rdata = 32'h0;
        if (mem_addr < 32'(DEPTH)) mem_rdata = ld(mem[mem_addr[6:0]], mem_mask);
    end

    always @(posedge clk) begin
        if (!mem_cs_n && !mem_rd && (mem_addr < 32'(DEPTH))) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[6:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input logic we, input logic [3:0] mask,
                                     input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.err   = (addr >= 32'(DEPTH)) || (!we && (mask > 4'd4));
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) ref_mem[addr[6:0]][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = ld(ref_mem[addr[6:0]], mask);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!mem_cs_n) begin
            cs_low_cnt++;
            last_cs_cyc = cyc;
        end
        if (p0_rvalid) begin
            rv0_cyc     = cyc;
            last_rdata0 = p0_rdata;
            last_err0   = p0_err;
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL p0_unexpected_rvalid observed=1 expected=0");
            end else begin
                e = q0.pop_front();
                chk("p0_rdata", p0_rdata, e.rdata);
                chk("p0_err", 32'(p0_err), 32'(e.err));
            end
        end
        if (p1_rvalid) begin
            last_err1 = p1_err;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL p1_unexpected_rvalid observed=1 expected=0");
            end else begin
                e = q1.pop_front();
                chk("p1_rdata", p1_rdata, e.rdata);
                chk("p1_err", 32'(p1_err), 32'(e.err));
            end
        end
    end

    // Raise one request at a negedge, wait (bounded) for its grant, drop it after the capturing edge.
    task automatic issue(input bit port, input logic we, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit push, output int gcyc);
        bit got = 1'b0;
        gcyc = -1;
        @(negedge clk);
        if (port) begin
            p1_we = we; p1_mask = mask; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_mask = mask; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end
        if (push) begin
            if (port) q1.push_back(predict(we, mask, addr, wdata));
            else      q0.push_back(predict(we, mask, addr, wdata));
        end
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (port ? p1_gnt : p0_gnt) begin
                got       = 1'b1;
                gcyc      = cyc;
                last_port = port;
                @(posedge clk);
                #1;
                if (port) p1_req = 1'b0;
                else      p0_req = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL gnt_timeout port=%0d observed=0 expected=1", port);
            p0_req = 1'b0;
            p1_req = 1'b0;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int g;
        bit first;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_mask = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_mask = 0; p1_addr = 0; p1_wdata = 0;
        b_p0_req = 0; b_p1_req = 0;
        settle(2);
        chk("rst_cs_n", 32'(mem_cs_n), 32'd1);
        chk("rst_rd", 32'(mem_rd), 32'd1);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        rst = 1'b0;
        settle(1);

        issue(1'b0, 1'b1, 4'hF, 32'd5, 32'hDEADBEEF, 1'b1, g);
        settle(3);
        chk("store_mem_cycle", 32'(last_cs_cyc), 32'(g + 1));

        issue(1'b0, 1'b0, 4'd2, 32'd5, 32'h0, 1'b1, g);
        settle(3);
        chk("lw_rvalid_latency", 32'(rv0_cyc), 32'(g + 2));
        chk("lw_rdata", last_rdata0, 32'hDEADBEEF);

        issue(1'b1, 1'b1, 4'hF, 32'd5, 32'h0000_80FF, 1'b1, g);
        settle(3);
        issue(1'b0, 1'b0, 4'd0, 32'd5, 32'h0, 1'b1, g);
        settle(3);
        chk("lb_rdata", last_rdata0, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 4'd3, 32'd5, 32'h0, 1'b1, g);
        settle(3);
        chk("lbu_rdata", last_rdata0, 32'h0000_00FF);

        cs_low_cnt = 0;
        issue(1'b0, 1'b0, 4'd7, 32'd5, 32'h0, 1'b1, g);
        settle(3);
        chk("bad_code_err", 32'(last_err0), 32'd1);
        chk("bad_code_no_cs", 32'(cs_low_cnt), 32'd0);

        issue(1'b1, 1'b1, 4'hF, 32'd101, 32'h1234_5678, 1'b1, g);
        settle(3);
        chk("oor_err", 32'(last_err1), 32'd1);
        chk("oor_no_cs", 32'(cs_low_cnt), 32'd0);

        issue(1'b0, 1'b1, 4'h0, 32'd5, 32'h1234_5678, 1'b1, g);
        settle(3);
        issue(1'b0, 1'b0, 4'd2, 32'd5, 32'h0, 1'b1, g);
        settle(3);
        chk("mask0_word5", mem[5], 32'h0000_80FF);

        // Round-robin: both ports held; winners alternate, one grant every two cycles.
        @(negedge clk);
        p0_we = 0; p0_mask = 4'd2; p0_addr = 32'd10; p0_req = 1'b1;
        p1_we = 0; p1_mask = 4'd2; p1_addr = 32'd11; p1_req = 1'b1;
        first = !last_port;
        for (int i = 0; i < 8; i++) begin
            bit w;
            #1;
            w = first ^ bit'((i / 2) % 2);
            chk("rr_gnt0", 32'(p0_gnt), 32'((i % 2 == 0) && !w));
            chk("rr_gnt1", 32'(p1_gnt), 32'((i % 2 == 0) && w));
            if (p0_gnt) q0.push_back(predict(1'b0, 4'd2, 32'd10, 32'h0));
            if (p1_gnt) q1.push_back(predict(1'b0, 4'd2, 32'd11, 32'h0));
            @(posedge clk);
            if (i == 7) begin
                #1;
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            @(negedge clk);
        end
        settle(3);

        // Fixed priority: port 1 forced to win once it has waited MAX_WAIT cycles.
        b_p0_req = 1'b1;
        b_p1_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("fp_gnt0", 32'(b_p0_gnt), 32'((i % 2 == 0) && (i != 8)));
            chk("fp_gnt1", 32'(b_p1_gnt), 32'(i == 8));
            @(posedge clk);
            if (i == 11) begin
                #1;
                b_p0_req = 1'b0;
                b_p1_req = 1'b0;
            end
            @(negedge clk);
        end
        settle(3);

        // Reset during the ACCESS cycle of a store: chip select drops at once, nothing commits.
        issue(1'b0, 1'b1, 4'hF, 32'd3, 32'hCAFE_F00D, 1'b0, g);
        chk("rst_store_driven", 32'(mem_cs_n), 32'd0);
        #1 rst = 1'b1;
        #1 chk("rst_async_cs_n", 32'(mem_cs_n), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        settle(4);
        chk("rst_word3", mem[3], ref_mem[3]);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
